// File: rtl/demux_1x2_stream_ctrl.sv
// Packet-aware 1x2 stream demux: routes valid/ready beats to one of two registered
// output buffers, locking each packet to a single port and counting completed packets.
module demux_1x2_stream_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t state, state_nxt;
  logic   rr_ptr, rr_nxt;
  logic   d;
  logic   acc;

  always_comb begin
    d         = mode ? rr_ptr : in_dest;
    state_nxt = state;
    rr_nxt    = rr_ptr;
    case (state)
      LOCK0:   d = 1'b0;
      LOCK1:   d = 1'b1;
      default: ;
    endcase
    // Ready depends only on the selected buffer, so no valid-to-ready loop exists.
    in_ready = d ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
    acc      = in_valid && in_ready;
    if (acc) begin
      if (in_last) begin
        state_nxt = IDLE;
        rr_nxt    = ~d;
      end else begin
        state_nxt = d ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_data  <= '0;
      out0_last  <= 1'b0;
      out0_valid <= 1'b0;
      pkt_cnt0   <= '0;
    end else begin
      if (out0_valid && out0_ready && out0_last)
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (acc && !d) begin
        out0_data  <= in_data;
        out0_last  <= in_last;
        out0_valid <= 1'b1;
      end else if (out0_valid && out0_ready) begin
        out0_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_data  <= '0;
      out1_last  <= 1'b0;
      out1_valid <= 1'b0;
      pkt_cnt1   <= '0;
    end else begin
      if (out1_valid && out1_ready && out1_last)
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      if (acc && d) begin
        out1_data  <= in_data;
        out1_last  <= in_last;
        out1_valid <= 1'b1;
      end else if (out1_valid && out1_ready) begin
        out1_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) || out0_valid || out1_valid;

endmodule
